// File: rtl/sp_ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port register-file RAM among NREQ requesters.
// Clears the RAM after reset before it accepts traffic; read data returns one cycle later, tagged one-hot.
module sp_ram_rr_arbiter #(
  parameter int DW    = 8,
  parameter int WORDS = 16,
  parameter int NREQ  = 4,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_din,
  input  logic [DW-1:0]      ram_qout,
  output logic               init_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   init_addr;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] rd_pend;
  logic            rd_oor;
  logic [DW-1:0]   rdata_last;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wdata;
  logic            g_we;
  logic            g_in_range;
  logic            xfer;

  // Cyclic first-valid search starting at rr_ptr.
  always_comb begin : grant_search
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_any && req_valid[PW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  assign gnt_oh     = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign g_addr     = req_addr[int'(gnt_idx)*AW +: AW];
  assign g_wdata    = req_wdata[int'(gnt_idx)*DW +: DW];
  assign g_we       = req_we[gnt_idx];
  assign g_in_range = int'(g_addr) < WORDS;
  assign xfer       = rst_n && (state == RUN) && gnt_any;

  always_comb begin
    state_next = state;
    req_ready  = '0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    if (rst_n) begin
      case (state)
        INIT: begin
          ram_we   = 1'b1;
          ram_addr = init_addr;
          if (init_addr == AW'(WORDS - 1)) state_next = RUN;
        end
        RUN: begin
          req_ready = gnt_oh;
          if (gnt_any) begin
            ram_addr = g_addr;
            ram_din  = g_wdata;
            ram_we   = g_we & g_in_range;
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      init_addr  <= '0;
      rr_ptr     <= '0;
      rd_pend    <= '0;
      rd_oor     <= 1'b0;
      rdata_last <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_addr <= init_addr + 1'b1;
      rd_pend <= (xfer && !g_we) ? gnt_oh : '0;
      if (xfer && !g_we) rd_oor <= !g_in_range;
      if (xfer) rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (|rsp_valid) rdata_last <= rsp_rdata;
    end
  end

  // NOTE: the RAM array itself has no reset; its contents are cleared by the INIT write sweep instead.
  // A read accepted just before reset is dropped, so the tag is masked while reset is asserted.
  assign rsp_valid = rd_pend & {NREQ{rst_n}};
  assign rsp_rdata = (|rsp_valid) ? (rd_oor ? '0 : ram_qout) : rdata_last;
  assign init_done = (state == RUN);

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Bench for sp_ram_rr_arbiter: a 4-requester/16-word instance driven from a vector table with a
// response scoreboard, and a 1-requester/12-word instance exercising out-of-range addresses.
module tb_sp_ram_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: NREQ=4, WORDS=16 ----------------
  logic        a_rst_n;
  logic [3:0]  a_valid, a_ready, a_we, a_rsp_valid;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  logic [7:0]  a_rsp_rdata, a_ram_din, a_ram_qout;
  logic        a_ram_we, a_init_done;
  logic [3:0]  a_ram_addr;

  sp_ram_rr_arbiter #(.DW(8), .WORDS(16), .NREQ(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_din(a_ram_din),
    .ram_qout(a_ram_qout), .init_done(a_init_done)
  );

  // ---------------- instance B: NREQ=1, WORDS=12 ----------------
  logic       b_rst_n;
  logic [0:0] b_valid, b_ready, b_we, b_rsp_valid;
  logic [3:0] b_addr, b_ram_addr;
  logic [7:0] b_wdata, b_rsp_rdata, b_ram_din, b_ram_qout;
  logic       b_ram_we, b_init_done;

  sp_ram_rr_arbiter #(.DW(8), .WORDS(12), .NREQ(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
    .ram_qout(b_ram_qout), .init_done(b_init_done)
  );

  // Register-file RAM models; scramble fills them with junk so the clear sweep is observable.
  logic       scramble;
  logic [7:0] a_mem [16];
  logic [7:0] b_mem [16];

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) begin
        a_mem[i] <= 8'hEE;
        b_mem[i] <= 8'hEE;
      end
    end else begin
      if (a_ram_we) a_mem[a_ram_addr] <= a_ram_din;
      if (b_ram_we) b_mem[b_ram_addr] <= b_ram_din;
    end
    a_ram_qout <= a_mem[a_ram_addr];
    b_ram_qout <= b_mem[b_ram_addr];
  end

  // ---------------- vector table and scoreboard for A ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic [3:0] vld;
    logic [7:0] data;
  } rsp_t;

  rsp_t       sb_q[$];
  logic [7:0] exp_mem [16];
  vec_t       vecs [18];

  task automatic apply_a(input vec_t v);
    int         g;
    logic [3:0] ea;
    logic [7:0] ed;
    logic       ew;
    rsp_t       r;
    a_valid = v.valid;
    a_we    = v.we;
    a_addr  = v.addr;
    a_wdata = v.wdata;
    @(negedge clk);
    check("a_req_ready", a_ready, v.exp_ready);
    g = -1;
    for (int i = 0; i < 4; i++) if (v.exp_ready[i]) g = i;
    ew = 1'b0; ea = '0; ed = '0;
    if (g >= 0) begin
      ea = v.addr[g*4 +: 4];
      ed = v.wdata[g*8 +: 8];
      ew = v.we[g];
    end
    check("a_ram_we", a_ram_we, ew);
    check("a_ram_addr", a_ram_addr, ea);
    check("a_ram_din", a_ram_din, ed);
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check("a_rsp_valid", a_rsp_valid, r.vld);
      check("a_rsp_rdata", a_rsp_rdata, r.data);
    end else begin
      check("a_rsp_valid_idle", a_rsp_valid, 4'b0000);
    end
    if (g >= 0) begin
      if (ew) exp_mem[ea] = ed;
      else sb_q.push_back('{vld: v.exp_ready, data: exp_mem[ea]});
    end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 right after reset release; returns at posedge+1 of the first request cycle.
  task automatic check_init_a();
    a_valid = 4'hF;
    a_we    = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("a_init_we", a_ram_we, 1'b1);
      check("a_init_addr", a_ram_addr, i);
      check("a_init_din", a_ram_din, 8'h00);
      check("a_init_ready", a_ready, 4'b0000);
      check("a_init_done_lo", a_init_done, 1'b0);
      if (i == 15) a_valid = 4'h0;
    end
    @(negedge clk);
    check("a_init_done_hi", a_init_done, 1'b1);
    check("a_idle_we", a_ram_we, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic b_step(input logic vld, input logic we, input logic [3:0] addr,
                        input logic [7:0] wdata, input logic exp_we,
                        input logic exp_rv, input logic [7:0] exp_rd);
    b_valid = vld;
    b_we    = we;
    b_addr  = addr;
    b_wdata = wdata;
    @(negedge clk);
    check("b_req_ready", b_ready, vld);
    check("b_ram_we", b_ram_we, exp_we);
    if (vld) check("b_ram_addr", b_ram_addr, addr);
    check("b_rsp_valid", b_rsp_valid, exp_rv);
    check("b_rsp_rdata", b_rsp_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    // {valid, we, addr {r3,r2,r1,r0}, wdata {r3,r2,r1,r0}, expected ready}
    vecs[0]  = '{4'hF, 4'hF, 16'h4321, 32'h13121110, 4'b0001};
    vecs[1]  = '{4'hF, 4'hF, 16'h4321, 32'h13121110, 4'b0010};
    vecs[2]  = '{4'hF, 4'hF, 16'h4321, 32'h13121110, 4'b0100};
    vecs[3]  = '{4'hF, 4'hF, 16'h4321, 32'h13121110, 4'b1000};
    vecs[4]  = '{4'hF, 4'h0, 16'h4321, 32'h0,        4'b0001};
    vecs[5]  = '{4'hF, 4'h0, 16'h4321, 32'h0,        4'b0010};
    vecs[6]  = '{4'b0100, 4'b0100, 16'h0500, 32'h00A50000, 4'b0100};
    vecs[7]  = '{4'b0001, 4'b0000, 16'h0005, 32'h0,  4'b0001};
    vecs[8]  = '{4'b0100, 4'b0000, 16'h0300, 32'h0,  4'b0100};
    for (int i = 9; i < 14; i++)
      vecs[i] = '{4'b0010, 4'b0000, 16'h0020, 32'h0, 4'b0010};
    vecs[14] = '{4'hF, 4'h0, 16'h4321, 32'h0,        4'b0100};
    vecs[15] = '{4'h0, 4'h0, 16'h0000, 32'h0,        4'b0000};
    vecs[16] = '{4'b1001, 4'h0, 16'h4321, 32'h0,     4'b1000};
    vecs[17] = '{4'h0, 4'h0, 16'h0000, 32'h0,        4'b0000};

    scramble = 1'b1;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_valid = 4'hF; a_we = 4'hF; a_addr = 16'h1234; a_wdata = 32'hDEADBEEF;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h3; b_wdata = 8'h77;
    repeat (3) @(posedge clk);
    #1 scramble = 1'b0;

    // Reset state: RAM port and ready forced low even with requests pending.
    @(negedge clk);
    check("rst_ram_we", a_ram_we, 1'b0);
    check("rst_ram_addr", a_ram_addr, 4'h0);
    check("rst_ram_din", a_ram_din, 8'h00);
    check("rst_ready", a_ready, 4'h0);
    check("rst_rsp_valid", a_rsp_valid, 4'h0);
    check("rst_rsp_rdata", a_rsp_rdata, 8'h00);
    check("rst_init_done", a_init_done, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);

    @(posedge clk); #1 a_rst_n = 1'b1;
    check_init_a();

    for (int i = 0; i < 18; i++) apply_a(vecs[i]);

    // Read accepted, then reset in the response cycle: no response, INIT reruns.
    apply_a('{4'b0001, 4'b0000, 16'h0001, 32'h0, 4'b0001});
    a_rst_n = 1'b0;
    a_valid = 4'h0;
    @(negedge clk);
    check("midrst_rsp_valid", a_rsp_valid, 4'h0);
    check("midrst_ready", a_ready, 4'h0);
    sb_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 a_rst_n = 1'b1;
    check_init_a();
    apply_a('{4'b0001, 4'b0000, 16'h0001, 32'h0, 4'b0001});
    apply_a('{4'b0010, 4'b0000, 16'h0050, 32'h0, 4'b0010});
    apply_a('{4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000});
    apply_a('{4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000});
    check("a_sb_empty", sb_q.size(), 0);

    // Instance B: 12-word clear, then out-of-range accesses.
    b_valid = 1'b0; b_we = 1'b0;
    b_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b_init_we", b_ram_we, 1'b1);
      check("b_init_addr", b_ram_addr, i);
      check("b_init_done_lo", b_init_done, 1'b0);
    end
    @(negedge clk);
    check("b_init_done_hi", b_init_done, 1'b1);
    @(posedge clk); #1;
    b_step(1'b1, 1'b1, 4'd13, 8'hFF, 1'b0, 1'b0, 8'h00);  // write addr13 suppressed
    b_step(1'b1, 1'b0, 4'd13, 8'h00, 1'b0, 1'b0, 8'h00);  // read addr13
    b_step(1'b1, 1'b1, 4'd11, 8'h5A, 1'b1, 1'b1, 8'h00);  // rsp(13)=0; write addr11
    b_step(1'b1, 1'b0, 4'd11, 8'h00, 1'b0, 1'b0, 8'h00);  // read addr11
    b_step(1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 8'h5A);  // rsp(11)=0x5A
    b_step(1'b1, 1'b0, 4'd13, 8'h00, 1'b0, 1'b0, 8'h5A);  // rdata holds; read addr13
    b_step(1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 8'h00);  // rsp(13)=0
    b_step(1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00);  // holds 0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
